// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state, opcode and mode constants plus pattern helpers
package blink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] OP_SET_EXP  = 2'd0;
  localparam logic [1:0] OP_SET_MODE = 2'd1;
  localparam logic [1:0] OP_START    = 2'd2;
  localparam logic [1:0] OP_STOP     = 2'd3;

  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;

  localparam logic [7:0] PAT_INIT = 8'h01;

  // Bounce direction for the next shift: the ends force a reversal before shifting.
  function automatic logic bounce_dir(input logic [7:0] pat, input logic dir_left);
    logic go_left;
    if (pat[7])      go_left = 1'b0;
    else if (pat[0]) go_left = 1'b1;
    else             go_left = dir_left;
    return go_left;
  endfunction

  function automatic logic [7:0] next_pattern(input logic [1:0] mode, input logic [7:0] pat,
                                              input logic dir_left);
    logic [7:0] res;
    case (mode)
      MODE_ROTL:   res = {pat[6:0], pat[7]};
      MODE_ROTR:   res = {pat[0], pat[7:1]};
      MODE_BOUNCE: res = bounce_dir(pat, dir_left) ? (pat << 1) : (pat >> 1);
      default:     res = ~pat;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/blink_seq_ctrl_if.sv
// rtl/blink_seq_ctrl_if.sv - command/status bundle between a driver and blink_seq_ctrl
interface blink_seq_ctrl_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - power-of-two prescaler producing a one-cycle tick
module blink_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic [3:0] exponent,
  output logic       tick
);

  logic [PRESC_W-1:0] r_count;
  logic [PRESC_W-1:0] w_limit;

  assign w_limit = (PRESC_W'(1) << exponent) - PRESC_W'(1);
  assign tick    = run && (r_count == w_limit);

  // Count while running; wrap on the terminal count, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (tick)   r_count <= '0;
    else if (run)    r_count <= r_count + PRESC_W'(1);
  end

endmodule

// File: rtl/blink_seq_ctrl.sv
// rtl/blink_seq_ctrl.sv - strobed-command LED pattern sequencer
module blink_seq_ctrl
  import blink_pkg::*;
#(
  parameter int         PRESC_W = 16,
  parameter logic [3:0] DEF_EXP = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0] r_state;
  logic [7:0] r_pattern;
  logic [1:0] r_mode;
  logic [3:0] r_exp;
  logic [2:0] r_step;
  logic       r_tick;
  logic       r_dir_left;
  logic       r_strobe;
  logic       r_armed;

  logic [1:0] w_state_nxt;
  logic [1:0] w_op;
  logic       w_cmd;
  logic       w_run;
  logic       w_presc_clear;
  logic       w_tick;
  logic       w_unused;

  assign w_unused = &{1'b0, uio_in, ui_in[4]};

  // r_armed blocks the first edge after reset so a strobe held across release is not a command.
  assign w_cmd = ui_in[7] & ~r_strobe & r_armed;
  assign w_op  = ui_in[6:5];
  assign w_run = (r_state == ST_RUN) && ena;
  assign w_presc_clear = w_cmd && ((w_op == OP_SET_EXP) ||
                                   ((w_op == OP_START) && (r_state == ST_IDLE)));

  blink_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .clear    (w_presc_clear),
    .exponent (r_exp),
    .tick     (w_tick)
  );

  // Strobe edge detector history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_strobe <= ui_in[7];
      r_armed  <= 1'b1;
    end
  end

  // Next state: commands first, then the enable-driven RUN/HOLD handover.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd && (w_op == OP_STOP))
      w_state_nxt = ST_IDLE;
    else if (w_cmd && (w_op == OP_START) && (r_state == ST_IDLE))
      w_state_nxt = ST_RUN;
    else if ((r_state == ST_RUN) && !ena)
      w_state_nxt = ST_HOLD;
    else if ((r_state == ST_HOLD) && ena)
      w_state_nxt = ST_RUN;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pattern, configuration and step counter; a command wins over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern  <= PAT_INIT;
      r_mode     <= MODE_ROTL;
      r_exp      <= DEF_EXP;
      r_step     <= 3'd0;
      r_tick     <= 1'b0;
      r_dir_left <= 1'b1;
    end else if (w_cmd) begin
      r_tick <= 1'b0;
      case (w_op)
        OP_SET_EXP: r_exp <= ui_in[3:0];
        OP_SET_MODE: begin
          r_mode     <= ui_in[1:0];
          r_pattern  <= PAT_INIT;
          r_dir_left <= 1'b1;
        end
        OP_STOP: begin
          r_pattern <= PAT_INIT;
          r_step    <= 3'd0;
        end
        default: ;
      endcase
    end else if (w_tick) begin
      r_pattern <= next_pattern(r_mode, r_pattern, r_dir_left);
      if (r_mode == MODE_BOUNCE)
        r_dir_left <= bounce_dir(r_pattern, r_dir_left);
      r_step <= r_step + 3'd1;
      r_tick <= 1'b1;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign uo_out  = r_pattern;
  assign uio_out = {r_step, r_mode, r_tick, (r_state == ST_HOLD), (r_state == ST_RUN)};
  assign uio_oe  = 8'hFF;

endmodule

// File: doc/blink_seq_ctrl.md
BLINK_SEQ_CTRL -- requirements
Module: blink_seq_ctrl

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, prescaler counter width.
REQ-002 SHALL have parameter DEF_EXP, default 4, reset value of the period exponent.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1, design enable.
REQ-006 SHALL have port ui_in, input, 8, command bus: [7] strobe, [6:5] opcode, [4:0] data.
REQ-007 SHALL have port uio_in, input, 8, unused and ignored.
REQ-008 SHALL have port uo_out, output, 8, LED pattern register.
REQ-009 SHALL have port uio_out, output, 8, status: [0] running, [1] hold, [2] tick, [4:3] mode, [7:5] step count.
REQ-010 SHALL have port uio_oe, output, 8, constant 8'hFF.

Function
REQ-011 SHALL register ui_in[7] each cycle and detect a command when ui_in[7]=1 and its registered value is 0; the command SHALL take effect at that same clock edge (visible one cycle after strobe rises).
REQ-012 SHALL execute opcode 00, SET_EXP: exponent <= data[3:0]; prescaler count cleared.
REQ-013 SHALL execute opcode 01, SET_MODE: mode <= data[1:0]; pattern <= 8'h01; bounce direction <= left.
REQ-014 SHALL execute opcode 10, START: IDLE->RUN with prescaler cleared; no effect in RUN or HOLD.
REQ-015 SHALL execute opcode 11, STOP: any state->IDLE; pattern <= 8'h01; step count <= 0.
REQ-016 SHALL implement states IDLE, RUN, HOLD: RUN with ena=0 ->HOLD; HOLD with ena=1 ->RUN; prescaler and pattern frozen in IDLE and HOLD.
REQ-017 SHALL, in RUN only, increment the prescaler each cycle and raise tick for one cycle when count = 2^exponent - 1, clearing count on the same edge (exponent 0 -> tick every cycle).
REQ-018 SHALL advance the pattern on each tick per mode: 0 rotate-left, 1 rotate-right, 2 bounce, 3 invert.
REQ-019 SHALL, in bounce mode, shift one-hot toward the current direction, reversing when bit 7 (go right) or bit 0 (go left) is set before the shift, i.e. 8'h80 -> 8'h40, 8'h01 -> 8'h02.
REQ-020 SHALL increment the 3-bit step count on each tick, wrapping 7->0.
REQ-021 SHALL give a command priority over a coincident tick: the tick pulse is suppressed and the pattern takes the command value.
REQ-022 SHALL drive uio_out[2] from the registered tick, aligned with the pattern update.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, uo_out=8'h01, mode 0, exponent DEF_EXP, prescaler 0, step count 0, tick 0, direction left, strobe register 0.
REQ-024 SHALL, on reset assertion mid-RUN, return all outputs to reset values immediately without waiting for clk.
REQ-025 SHALL ignore a strobe held high across reset release until it falls and rises again.

Structure
REQ-026 SHALL place the state encoding, opcode constants and mode constants in shared package blink_pkg.
REQ-027 SHALL implement the prescaler as sub-module blink_prescaler (inputs run, clear, exponent; output tick).

Verification
REQ-028 SHALL verify: reset, START, exponent 0, mode 0 -> uo_out 8'h02, 8'h04, ... 8'h80, 8'h01 on consecutive cycles; uio_out[0]=1.
REQ-029 SHALL verify: SET_EXP 3, START -> tick every 8 cycles; step count reads 1..7 then 0 after 8 ticks.
REQ-030 SHALL verify: mode 2, exponent 0 -> 01,02,...,80,40,...,01,02 sequence.
REQ-031 SHALL verify: ena dropped for 5 cycles in RUN -> uio_out[1]=1, pattern frozen; resumes from the same prescaler count on ena high.
REQ-032 SHALL verify: SET_MODE strobe on the tick cycle -> pattern 8'h01, no tick pulse, step count unchanged.
REQ-033 SHALL verify: rst_n low mid-RUN, strobe held high through release -> outputs at reset values; no command executes until strobe re-toggles.
